audio_pwm: RTL and testbench
============================

// Module: audio_pwm
// PURPOSE
//  - Downstream of the pulse channel: converts its signed 5-bit DAC sample to a 1-bit PWM audio pin.
//  - Soft ramp state machine swings duty 0 <-> midscale on enable/disable, preventing clicks at power-up/mute.
//  - Carrier = clk / 2**WIDTH; an external RC filter recovers the audio.
// PARAMETERS
//  - WIDTH     5  sample width; also PWM counter width (frame = 2**WIDTH clocks)
//  - RAMP_DIV  1  frames per one-LSB ramp step (>=1)
// PORTS
//  - clk     in   1      system clock (same clock as the APU)
//  - rst_n   in   1      asynchronous, active-low reset
//  - ena     in   1      1 = play, 0 = ramp to silence
//  - sample  in   WIDTH  signed two's-complement sample from pulse channel
//  - pwm     out  1      modulated audio output
//  - frame   out  1      1-clk strobe at counter 0 (duty latched this cycle)
//  - active  out  1      1 while state == RUN
// BEHAVIOUR
//  - Reset: cnt=0, duty=0, state=IDLE, pwm=0, frame=0, active=0; ramp divider cleared.
//  - cnt free-runs 0..2**WIDTH-1, wraps; frame=1 when cnt==0.
//  - Offset conversion: code = sample with MSB inverted (-16->0, 0->16, +15->31); MID = 2**(WIDTH-1).
//  - duty updates only on frame cycles; sample sampled only then (mid-frame changes ignored).
//  - pwm = (cnt < duty), registered -> 1 clk latency from cnt; duty 0 = always low, max = 31/32 high.
//  - FSM (evaluated on frame cycles only; ramp steps gated by RAMP_DIV divider):
//      IDLE      : duty=0; ena=1 -> RAMP_UP.
//      RAMP_UP   : duty steps 1 LSB toward MID; duty==MID -> RUN; ena=0 -> RAMP_DOWN.
//      RUN       : duty=code; ena=0 -> RAMP_DOWN (first step from current code).
//      RAMP_DOWN : duty decrements 1 LSB; duty==0 -> IDLE; ena=1 -> RAMP_UP (from current duty).
//  - RAMP_UP toward MID steps up or down as needed (entry from RAMP_DOWN at duty>MID allowed).
//  - RUN entry: first RUN frame loads code directly (no ramp MID->code).
//  - ena toggled mid-frame: acted on at next frame only; reversal is glitch-free, 1 LSB/step.
//  - Reset mid-frame: pwm forced 0 immediately (async), restart from IDLE.
//  - No overflow: all duty arithmetic saturates in [0, 2**WIDTH-1].
// CONFIGURATION
//  - AUDIO_PWM_DSM_EN defined: comparator replaced by 1st-order sigma-delta:
//      acc (WIDTH+1 bits) <= acc[WIDTH-1:0] + duty each clk; pwm = acc[WIDTH] (carry), registered.
//      Same mean density duty/2**WIDTH, higher-frequency noise; cnt/frame/FSM unchanged; acc reset 0.
//  - Undefined: plain counter-compare PWM as above.
// STRUCTURE
//  - audio_pkg: FSM state enum (IDLE, RAMP_UP, RUN, RAMP_DOWN), MID, to_offset() function.
//  - Sub-module pwm_core: cnt, frame strobe, comparator or DSM accumulator; duty as input.
//  - audio_pwm top: FSM, ramp divider, duty register, instantiates pwm_core.
// TESTING
//  - Reset, ena=0 for 10 frames -> pwm constantly 0, active=0, frame every 32 clks.
//  - ena=1, sample=0 -> duty 1,2..16 on successive frames, active=1 on 17th frame; pwm 16/32 high.
//  - RUN, sample=+15 -> 31 high clks/frame; sample=-16 -> 0 high; change mid-frame applies next frame.
//  - RUN duty 20, ena=0 -> duty 19,18..0 then IDLE; ena=1 at duty 8 -> ramps 9..16 back up.
//  - rst_n low mid-frame with pwm=1 -> pwm=0 same cycle; release -> IDLE, duty 0.
//  - DSM_EN build, RUN duty 8 -> exactly 8 ones per 32-clk window, no run longer than 1 clk high.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the PWM audio output stage.
// Offset conversion maps a signed sample onto an unsigned duty code.
package audio_pkg;

    localparam int AUDIO_WIDTH = 5;
    localparam int MID         = 2 ** (AUDIO_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RUN,
        RAMP_DOWN
    } state_t;

    function automatic logic [31:0] mid_of(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Two's complement to offset binary: flipping the sign bit adds MID.
    function automatic logic [31:0] to_offset(input logic [31:0] s, input int w);
        return s ^ (32'd1 << (w - 1));
    endfunction

endpackage

// File: rtl/audio_pwm_if.sv
// Sample-in / PWM-out bundle between the pulse channel and the audio pin stage.
interface audio_pwm_if import audio_pkg::*; #(
    parameter int WIDTH = AUDIO_WIDTH
);
    logic                    ena;
    logic signed [WIDTH-1:0] sample;
    logic                    pwm;
    logic                    frame;
    logic                    active;

    modport master (output ena, sample, input pwm, frame, active);
    modport slave  (input ena, sample, output pwm, frame, active);
endinterface

// File: rtl/pwm_core.sv
// Free-running frame counter plus PWM modulator (counter compare, or 1st-order sigma-delta with AUDIO_PWM_DSM_EN).
// Latency: pwm registered, 1 clk after the duty/count it reflects; frame strobes when cnt==0.
// Backpressure: none, free-running every clock.
module pwm_core import audio_pkg::*; #(
    parameter int WIDTH = AUDIO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm,
    output logic             frame
);

    logic [WIDTH-1:0] cnt;

    // Strobe is registered so it lines up with cnt==0 and stays low in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= cnt + WIDTH'(1);
            frame <= (cnt == '1);
        end
    end

`ifdef AUDIO_PWM_DSM_EN
    logic [WIDTH:0] acc;

    // Carry out of the residue is the output bit: density duty/2**WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= {1'b0, acc[WIDTH-1:0]} + {1'b0, duty};
        end
    end

    assign pwm = acc[WIDTH];
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < duty);
        end
    end
`endif

endmodule

// File: rtl/audio_pwm.sv
// Signed sample to 1-bit PWM audio pin with click-free soft ramp on enable/mute; AUDIO_PWM_DSM_EN selects sigma-delta.
// Latency: ena/sample taken on frame strobe only, duty applies from that frame; pwm 1 clk behind the counter.
// Backpressure: none, inputs are sampled once per 2**WIDTH-clock frame and ignored otherwise.
module audio_pwm import audio_pkg::*; #(
    parameter int WIDTH    = AUDIO_WIDTH,
    parameter int RAMP_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    audio_pwm_if.slave  bus
);

    localparam logic [WIDTH-1:0] MID_W    = WIDTH'(mid_of(WIDTH));
    localparam int               DW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0]    DIV_LAST = DW'(RAMP_DIV - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] duty, duty_nxt, code;
    logic [DW-1:0]    div, div_nxt;
    logic             frame, step;

    assign code = WIDTH'(to_offset(32'(bus.sample), WIDTH));

    // Steps only move toward a bound that is already known to be on the far
    // side, so increments never wrap past 2**WIDTH-1 and decrements never go below 0.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        div_nxt   = div;
        step      = (div == DIV_LAST);
        if (frame) begin
            case (state)
                IDLE: begin
                    duty_nxt = '0;
                    div_nxt  = '0;
                    if (bus.ena) state_nxt = RAMP_UP;
                end
                RAMP_UP: begin
                    if (!bus.ena) begin
                        state_nxt = RAMP_DOWN;
                        div_nxt   = '0;
                    end else if (duty == MID_W) begin
                        state_nxt = RUN;
                        div_nxt   = '0;
                    end else begin
                        div_nxt = step ? '0 : div + DW'(1);
                        if (step) begin
                            duty_nxt = (duty < MID_W) ? duty + WIDTH'(1) : duty - WIDTH'(1);
                            if (duty_nxt == MID_W) state_nxt = RUN;
                        end
                    end
                end
                RUN: begin
                    div_nxt = '0;
                    if (!bus.ena) state_nxt = RAMP_DOWN;
                    else          duty_nxt  = code;
                end
                RAMP_DOWN: begin
                    if (bus.ena) begin
                        state_nxt = RAMP_UP;
                        div_nxt   = '0;
                    end else if (duty == '0) begin
                        state_nxt = IDLE;
                        div_nxt   = '0;
                    end else begin
                        div_nxt = step ? '0 : div + DW'(1);
                        if (step) begin
                            duty_nxt = duty - WIDTH'(1);
                            if (duty_nxt == '0) state_nxt = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    duty_nxt  = '0;
                    div_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            duty  <= '0;
            div   <= '0;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            div   <= div_nxt;
        end
    end

    // The modulator sees the new duty during the strobe cycle itself, so each
    // 2**WIDTH-clock window carries exactly one duty value.
    pwm_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .duty  (duty_nxt),
        .pwm   (bus.pwm),
        .frame (frame)
    );

    assign bus.frame  = frame;
    assign bus.active = (state == RUN);

endmodule

// File: tb/tb_audio_pwm.sv
// Bench for audio_pwm: per-frame scoreboard against a frame-level model, vector table, hand corner cases, random phase.
module tb_audio_pwm;
    import audio_pkg::*;

    localparam int W  = AUDIO_WIDTH;
    localparam int FR = 2 ** W;
    localparam int M_IDLE = 0, M_UP = 1, M_RUN = 2, M_DOWN = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    audio_pwm_if #(.WIDTH(W)) bus();

    audio_pwm #(.WIDTH(W), .RAMP_DIV(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: one decision per strobe, duty as plain integer.
    int m_mode, m_duty, m_code;
    int hi, run, max_run, since, win_act, last_hi, last_act;
    int frame_no = 0;
    bit have_prev, win_first;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_IDLE; m_duty = 0;
            hi = 0; run = 0; max_run = 0; since = 0;
            have_prev = 0; win_first = 0;
        end else begin
            since++;
            if (win_first) begin
                win_act = int'(bus.active);
                win_first = 0;
            end
            if (bus.pwm) begin
                hi++; run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (bus.frame) begin
                if (have_prev) begin
                    check("frame_period", since, FR);
                    check("win_high", hi, m_duty);
                    check("win_active", win_act, int'(m_mode == M_RUN));
`ifdef AUDIO_PWM_DSM_EN
                    if (m_duty <= MID) check("dsm_max_run_le1", int'(max_run <= 1), 1);
`else
                    check("pwm_contiguous", max_run, hi);
`endif
                    last_hi  = hi;
                    last_act = win_act;
                end
                m_code = int'(bus.sample) + MID;
                case (m_mode)
                    M_IDLE: begin
                        m_duty = 0;
                        if (bus.ena) m_mode = M_UP;
                    end
                    M_UP: begin
                        if (!bus.ena) m_mode = M_DOWN;
                        else if (m_duty == MID) m_mode = M_RUN;
                        else begin
                            m_duty += (m_duty < MID) ? 1 : -1;
                            if (m_duty == MID) m_mode = M_RUN;
                        end
                    end
                    M_RUN: begin
                        if (!bus.ena) m_mode = M_DOWN;
                        else m_duty = m_code;
                    end
                    default: begin
                        if (bus.ena) m_mode = M_UP;
                        else if (m_duty == 0) m_mode = M_IDLE;
                        else begin
                            m_duty--;
                            if (m_duty == 0) m_mode = M_IDLE;
                        end
                    end
                endcase
                hi = 0; run = 0; max_run = 0; since = 0;
                have_prev = 1; win_first = 1;
                frame_no++;
            end
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int cyc;
        target = frame_no + n;
        cyc = 0;
        while (frame_no < target && cyc < n * FR + 8) begin
            @(negedge clk);
            cyc++;
        end
        if (frame_no < target) check("frame_timeout", frame_no, target);
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        bit ena;
        int sample;
        int frames;
        int exp_hi;
        int exp_act;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{0,   0, 10,  0, 0});
        tbl.push_back('{1,   0, 17, 16, 1});
        tbl.push_back('{1,  15,  1, 31, 1});
        tbl.push_back('{1, -16,  1,  0, 1});
        tbl.push_back('{1,  -8,  1,  8, 1});
        tbl.push_back('{1,   4,  1, 20, 1});
        tbl.push_back('{0,   4,  1, 20, 0});
        tbl.push_back('{0,   4, 10,  9, 0});
        tbl.push_back('{1,   0,  1,  8, 0});
        tbl.push_back('{1,   0,  6, 15, 0});
        tbl.push_back('{1,   0,  1, 16, 1});
        tbl.push_back('{0,   0,  1, 16, 0});
        tbl.push_back('{0,   0, 16,  0, 0});

        bus.ena = 1'b0;
        bus.sample = '0;
        #23;
        check("rst_pwm", int'(bus.pwm), 0);
        check("rst_frame", int'(bus.frame), 0);
        check("rst_active", int'(bus.active), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Each vector: hold inputs n frames, then measure the window decided at frame n.
        foreach (tbl[i]) begin
            bus.ena    = tbl[i].ena;
            bus.sample = W'(tbl[i].sample);
            wait_frames(tbl[i].frames + 1);
            check($sformatf("vec%0d_high", i), last_hi, tbl[i].exp_hi);
            check($sformatf("vec%0d_active", i), last_act, tbl[i].exp_act);
        end

        // Mid-frame sample change only takes effect at the next strobe.
        bus.ena = 1'b1;
        bus.sample = '0;
        wait_frames(18);
        repeat (14) @(posedge clk);
        #2 bus.sample = W'(15);
        wait_frames(1);
        check("midchg_old_window", last_hi, 16);
        wait_frames(1);
        check("midchg_new_window", last_hi, 31);

        // Reset while pwm is high drops the pin immediately.
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_pwm", int'(bus.pwm), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pwm", int'(bus.pwm), 0);
        check("async_rst_active", int'(bus.active), 0);
        check("async_rst_frame", int'(bus.frame), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_frames(2);
        check("post_rst_high", last_hi, 0);
        check("post_rst_active", last_act, 0);

        // Random phase: occasional ena flips, new samples, some mid-frame changes.
        for (int f = 0; f < 200; f++) begin
            if ($urandom_range(0, 9) == 0) bus.ena = ~bus.ena;
            bus.sample = W'($urandom_range(0, FR - 1));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 25)) @(posedge clk);
                #2 bus.sample = W'($urandom_range(0, FR - 1));
            end
            wait_frames(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
